// File: rtl/vend_pkg.sv
// Shared constants and state type for the change dispenser.
// Holds the default price, tube fill count, coin denominations and FSM states.
package vend_pkg;

   localparam int PRICE_DEF    = 10;
   localparam int INV_INIT_DEF = 15;

   localparam logic [3:0] COIN5    = 4'd5;
   localparam logic [3:0] COIN2    = 4'd2;
   localparam logic [3:0] COIN1    = 4'd1;
   localparam logic [3:0] COIN0    = 4'd0;
   localparam logic [3:0] INV_FULL = 4'd15;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      FINISH
   } state_t;

endpackage

// File: rtl/change_denom_sel.sv
// Greedy denomination picker: largest available coin not above remaining.
// Ports: remaining (5b), avail5/avail2 (tube not empty) -> coin (5, 2, 1 or 0).
module change_denom_sel
   import vend_pkg::*;
(
   input  logic [4:0] remaining,
   input  logic       avail5,
   input  logic       avail2,
   output logic [3:0] coin
);

   // 1-coins are never exhausted, so any non-zero remainder
   // always yields some coin.
   always_comb begin
      coin = COIN0;
      if (remaining >= 5'd5 && avail5) begin
         coin = COIN5;
      end else if (remaining >= 5'd2 && avail2) begin
         coin = COIN2;
      end else if (remaining != 5'd0) begin
         coin = COIN1;
      end
   end

endmodule

// File: rtl/vend_change_dispenser.sv
// Change dispenser: on start, pays out credit - PRICE as 5/2/1 coins over a
// valid/ready hopper handshake, then pulses done (or err if credit < PRICE).
// Ports: clk, rst (sync, active high), start, credit[4:0], coin_out[3:0],
//   coin_valid, coin_ready, busy, done, err; refill when inventory is enabled.
// Macro VEND_CHANGE_INVENTORY_EN adds 5/2 tube counters and the refill input.
module vend_change_dispenser
   import vend_pkg::*;
#(
   parameter int PRICE    = PRICE_DEF,
   parameter int INV_INIT = INV_INIT_DEF
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [4:0] credit,
`ifdef VEND_CHANGE_INVENTORY_EN
   input  logic       refill,
`endif
   input  logic       coin_ready,
   output logic [3:0] coin_out,
   output logic       coin_valid,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam logic [4:0] PRICE5 = 5'(PRICE);

   state_t     state;
   logic [4:0] remaining;
   logic [4:0] rem_nxt;
   logic       hs;
   logic       ok;
   logic       avail5;
   logic       avail2;
   logic [3:0] pick;

   assign hs = coin_valid & coin_ready;
   assign ok = credit >= PRICE5;

   // Remainder as it will be after this edge; the picker runs on it so the
   // next coin offered already reflects the coin just accepted.
   always_comb begin
      rem_nxt = remaining;
      unique case (state)
         IDLE: begin
            if (start && ok) begin
               rem_nxt = credit - PRICE5;
            end
         end
         ISSUE: begin
            if (hs) begin
               rem_nxt = remaining - {1'b0, coin_out};
            end
         end
         default: rem_nxt = remaining;
      endcase
   end

`ifdef VEND_CHANGE_INVENTORY_EN
   localparam logic [3:0] INV0 = 4'(INV_INIT);

   logic [3:0] cnt5;
   logic [3:0] cnt2;
   logic [3:0] cnt5_nxt;
   logic [3:0] cnt2_nxt;

   // Refill wins over a simultaneous acceptance.
   always_comb begin
      cnt5_nxt = cnt5;
      cnt2_nxt = cnt2;
      if (hs && coin_out == COIN5) begin
         cnt5_nxt = cnt5 - 4'd1;
      end
      if (hs && coin_out == COIN2) begin
         cnt2_nxt = cnt2 - 4'd1;
      end
      if (refill) begin
         cnt5_nxt = INV_FULL;
         cnt2_nxt = INV_FULL;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt5 <= INV0;
         cnt2 <= INV0;
      end else begin
         cnt5 <= cnt5_nxt;
         cnt2 <= cnt2_nxt;
      end
   end

   assign avail5 = cnt5_nxt != 4'd0;
   assign avail2 = cnt2_nxt != 4'd0;
`else
   assign avail5 = 1'b1;
   assign avail2 = 1'b1;
`endif

   change_denom_sel u_sel (
      .remaining (rem_nxt),
      .avail5    (avail5),
      .avail2    (avail2),
      .coin      (pick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         remaining  <= 5'd0;
         coin_valid <= 1'b0;
         coin_out   <= COIN0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start && !ok) begin
                  err <= 1'b1;
               end else if (start) begin
                  remaining <= rem_nxt;
                  if (rem_nxt != 5'd0) begin
                     state      <= ISSUE;
                     busy       <= 1'b1;
                     coin_valid <= 1'b1;
                     coin_out   <= pick;
                  end else begin
                     state <= FINISH;
                     done  <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (hs) begin
                  remaining <= rem_nxt;
                  if (rem_nxt == 5'd0) begin
                     state      <= FINISH;
                     busy       <= 1'b0;
                     coin_valid <= 1'b0;
                     coin_out   <= COIN0;
                     done       <= 1'b1;
                  end else begin
                     coin_out <= pick;
                  end
               end
            end
            FINISH: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Self-checking bench for vend_change_dispenser: vector table, corner-case
// sequences and random transactions against a greedy-change model.
module tb_vend_change_dispenser;

   localparam int PRICE = 10;
   localparam int INV   = 15;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [4:0] credit = 5'd0;
   logic       coin_ready = 1'b0;
   logic       refill = 1'b0;
   logic [3:0] coin_out;
   logic       coin_valid;
   logic       busy;
   logic       done;
   logic       err;

   int total = 0;
   int passed = 0;
   int m_cnt5 = 1000;
   int m_cnt2 = 1000;

   always #5 clk = ~clk;

   vend_change_dispenser #(.PRICE(PRICE), .INV_INIT(INV)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .credit     (credit),
`ifdef VEND_CHANGE_INVENTORY_EN
      .refill     (refill),
`endif
      .coin_ready (coin_ready),
      .coin_out   (coin_out),
      .coin_valid (coin_valid),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   function automatic void chk(string nm, int act, int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endfunction

   // Model: change = credit - PRICE paid greedily from the tubes as they
   // stand, 1-coins unlimited.
   function automatic void ref_change(input int cr, output bit e,
                                      output int n, output logic [63:0] coins);
      int ch, c5, c2, d;
      e = cr < PRICE;
      n = 0;
      coins = '0;
      if (e) return;
      ch = cr - PRICE;
      c5 = m_cnt5;
      c2 = m_cnt2;
      while (ch > 0) begin
         if (ch >= 5 && c5 > 0) begin d = 5; c5--; end
         else if (ch >= 2 && c2 > 0) begin d = 2; c2--; end
         else d = 1;
         coins[n*4 +: 4] = 4'(d);
         n++;
         ch -= d;
      end
   endfunction

   task automatic model_reset();
`ifdef VEND_CHANGE_INVENTORY_EN
      m_cnt5 = INV;
      m_cnt2 = INV;
`endif
   endtask

   task automatic run_txn(input logic [4:0] cr, input bit exp_err,
                          input int n, input logic [63:0] coins,
                          input bit rnd, input int stall);
      int k, cyc;
      start = 1'b1;
      credit = cr;
      @(posedge clk); #1;
      start = 1'b0;
      coin_ready = 1'b0;
      if (exp_err) begin
         chk("err_pulse", int'(err), 1);
         chk("err_busy", int'(busy), 0);
         chk("err_valid", int'(coin_valid), 0);
         chk("err_done", int'(done), 0);
         @(posedge clk); #1;
         chk("err_once", int'(err), 0);
         chk("err_valid2", int'(coin_valid), 0);
         chk("err_done2", int'(done), 0);
         return;
      end
      k = 0;
      cyc = 0;
      while (k < n && cyc < 100) begin
         chk("valid", int'(coin_valid), 1);
         chk("coin", int'(coin_out), int'(coins[k*4 +: 4]));
         chk("busy", int'(busy), 1);
         chk("no_done", int'(done), 0);
         if (cyc < stall) coin_ready = 1'b0;
         else if (rnd) coin_ready = 1'($urandom_range(0, 1));
         else coin_ready = 1'b1;
         if (rnd) begin
            start = 1'($urandom_range(0, 1));
            credit = 5'($urandom_range(0, 24));
         end
         @(posedge clk); #1;
         cyc++;
         if (coin_ready) begin
`ifdef VEND_CHANGE_INVENTORY_EN
            if (coins[k*4 +: 4] == 4'd5) m_cnt5--;
            if (coins[k*4 +: 4] == 4'd2) m_cnt2--;
`endif
            k++;
         end
      end
      if (cyc >= 100) chk("txn_timeout", k, n);
      coin_ready = 1'b0;
      start = 1'b0;
      chk("done", int'(done), 1);
      chk("done_busy", int'(busy), 0);
      chk("done_valid", int'(coin_valid), 0);
      chk("done_err", int'(err), 0);
      @(posedge clk); #1;
      chk("done_once", int'(done), 0);
      chk("idle_busy", int'(busy), 0);
      chk("idle_valid", int'(coin_valid), 0);
   endtask

   typedef struct {
      logic [4:0]  credit;
      bit          err;
      int          n;
      logic [63:0] coins;
   } vec_t;

   vec_t tbl[12];

   initial begin
      bit          e;
      int          n;
      logic [63:0] cs;

      tbl[0]  = '{5'd18, 1'b0, 3, 64'h125};
      tbl[1]  = '{5'd10, 1'b0, 0, 64'h0};
      tbl[2]  = '{5'd24, 1'b0, 4, 64'h2255};
      tbl[3]  = '{5'd7,  1'b1, 0, 64'h0};
      tbl[4]  = '{5'd17, 1'b0, 2, 64'h25};
      tbl[5]  = '{5'd11, 1'b0, 1, 64'h1};
      tbl[6]  = '{5'd13, 1'b0, 2, 64'h12};
      tbl[7]  = '{5'd15, 1'b0, 1, 64'h5};
      tbl[8]  = '{5'd0,  1'b1, 0, 64'h0};
      tbl[9]  = '{5'd9,  1'b1, 0, 64'h0};
      tbl[10] = '{5'd16, 1'b0, 2, 64'h15};
      tbl[11] = '{5'd12, 1'b0, 1, 64'h2};

      rst = 1'b1;
      model_reset();
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_valid", int'(coin_valid), 0);
      chk("rst_coin", int'(coin_out), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++) begin
         run_txn(tbl[i].credit, tbl[i].err, tbl[i].n, tbl[i].coins, 1'b0, 0);
      end

      // First coin stalled three cycles, must stay 5.
      run_txn(5'd24, 1'b0, 4, 64'h2255, 1'b0, 3);

      // Reset after the first acceptance.
      start = 1'b1;
      credit = 5'd17;
      @(posedge clk); #1;
      start = 1'b0;
      chk("mid_coin5", int'(coin_out), 5);
      coin_ready = 1'b1;
      @(posedge clk); #1;
      chk("mid_coin2", int'(coin_out), 2);
      rst = 1'b1;
      coin_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      chk("mid_rst_valid", int'(coin_valid), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_done", int'(done), 0);
      chk("mid_rst_coin", int'(coin_out), 0);
      @(posedge clk); #1;
      chk("mid_idle_valid", int'(coin_valid), 0);
      run_txn(5'd17, 1'b0, 2, 64'h25, 1'b0, 0);

`ifdef VEND_CHANGE_INVENTORY_EN
      while (m_cnt5 > 0) begin
         ref_change(15, e, n, cs);
         run_txn(5'd15, e, n, cs, 1'b0, 0);
      end
      run_txn(5'd17, 1'b0, 4, 64'h1222, 1'b0, 0);
      refill = 1'b1;
      @(posedge clk); #1;
      refill = 1'b0;
      m_cnt5 = 15;
      m_cnt2 = 15;
      run_txn(5'd15, 1'b0, 1, 64'h5, 1'b0, 0);
`endif

      for (int i = 0; i < 40; i++) begin
         int cr;
         cr = $urandom_range(0, 24);
         ref_change(cr, e, n, cs);
         run_txn(5'(cr), e, n, cs, 1'b1, 0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/vend_change_dispenser.md
VEND_CHANGE_DISPENSER -- requirements
Module: vend_change_dispenser

Interface
REQ-001 SHALL have parameter PRICE, default 10, meaning drink cost in rupees.
REQ-002 SHALL have parameter INV_INIT, default 15, meaning the reset fill count of each of the 5-coin and 2-coin tubes.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single system clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit, meaning the synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit, meaning a one-cycle request from the coin-sum FSM to return change.
REQ-006 SHALL have port credit, input, 5 bits, meaning the total inserted amount in rupees, 0..24.
REQ-007 SHALL have port coin_out, output, 4 bits, meaning the denomination offered: 5, 2 or 1.
REQ-008 SHALL have port coin_valid, output, 1 bit, meaning coin_out is being offered to the hopper.
REQ-009 SHALL have port coin_ready, input, 1 bit, meaning the hopper accepts the offered coin.
REQ-010 SHALL have port busy, output, 1 bit, meaning a change transaction is in progress.
REQ-011 SHALL have port done, output, 1 bit, meaning a one-cycle pulse when a transaction completes.
REQ-012 SHALL have port err, output, 1 bit, meaning a one-cycle pulse when credit < PRICE at start.

Function
REQ-013 SHALL implement states IDLE, ISSUE and FINISH.
REQ-014 SHALL, in IDLE, sample start at a clock edge and load remaining = credit - PRICE (5-bit, unsigned) when credit >= PRICE.
- Next state: ISSUE if remaining > 0; FINISH if remaining = 0.
REQ-015 SHALL, when start is sampled with credit < PRICE, stay in IDLE, pulse err in the following cycle and issue no coin.
REQ-016 SHALL ignore start while busy is high.
REQ-017 SHALL, in ISSUE, drive coin_valid high with coin_out = largest available denomination <= remaining.
- coin_valid SHALL first be high in the cycle after the start edge.
REQ-018 SHALL hold coin_out stable while coin_valid is high and coin_ready is low.
REQ-019 SHALL, on an edge where coin_valid and coin_ready are both high, subtract coin_out from remaining.
- Back-to-back offers SHALL be allowed, so coin_valid may stay high.
- Next state: FINISH when the new remaining = 0, otherwise stay in ISSUE.
REQ-020 SHALL, in FINISH, drive done high for exactly one cycle with busy low, then return to IDLE.
REQ-021 SHALL drive busy high in ISSUE and in the FINISH-entry path, and low in IDLE.
REQ-022 SHALL never offer a coin larger than remaining, and remaining SHALL never underflow.

Reset
REQ-023 SHALL, with rst high at a clock edge, set state IDLE, remaining 0, coin_valid 0, coin_out 0, busy 0, done 0 and err 0.
REQ-024 SHALL, on reset mid-transaction, abandon the outstanding change, with coin_valid low from the cycle after the edge.
REQ-025 SHALL give rst priority over start and coin_ready.

Configuration
REQ-026 SHALL use macro VEND_CHANGE_INVENTORY_EN.
- Defined: 4-bit counters cnt5 and cnt2 reset to INV_INIT; each decrements on acceptance of its denomination.
- Defined: a denomination with count 0 is skipped in favour of the next smaller one; 1-coins are unlimited.
- Defined: an added input refill (1 bit) sets both counters to 15, and an input refill coinciding with acceptance yields 15.
- Undefined: every denomination is unlimited, and the refill port and counters are absent.

Structure
REQ-027 SHALL place PRICE default, denomination constants (5, 2, 1) and the state enum in shared package vend_pkg.
REQ-028 SHALL implement the combinational greedy picker as sub-module change_denom_sel.
- Inputs: remaining and availability flags.
- Output: the denomination.

Verification
REQ-029 SHALL cover: credit 18, start, coin_ready held high -> coins 5,2,1 on consecutive cycles, then a done pulse.
REQ-030 SHALL cover: credit 10, start -> no coin_valid, with done pulsing in the cycle after start.
REQ-031 SHALL cover: credit 24, coin_ready low for 3 cycles on the first coin -> coin_out=5 held stable, then 5,5,2,2, then done.
REQ-032 SHALL cover: credit 7, start -> err pulses once, with busy, coin_valid and done staying 0.
REQ-033 SHALL cover: credit 17, rst asserted after the first acceptance -> coin_valid low next cycle, IDLE, and a new start works normally.
REQ-034 SHALL cover, with VEND_CHANGE_INVENTORY_EN, cnt5 = 0 and credit 17 -> coins 2,2,2,1, then done.
